// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32 instruction-fetch front end.
package rv32_pkg;

  localparam int PC_W       = 12;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // A fetch target is legal only when it lands on a word boundary.
  function automatic logic is_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO holding fetched {inst, inst_pc} pairs for the datapath.
module fetch_fifo #(
  parameter int DW = 44
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [DW-1:0] head_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] entry_q [2];
  logic          rd_ptr_q;
  logic          wr_ptr_q;
  logic [1:0]    count_q;
  logic [1:0]    count_d;

  // Occupancy after this cycle's push and pop.
  always_comb begin
    count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  // Pointer and occupancy bookkeeping; a flush discards every entry at once.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset: count_q alone says which slots are live.
  always_ff @(posedge clk) begin
    if (push_i) entry_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = entry_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: byte-programmable instruction memory, word fetch with a
// one-cycle read, two-entry result buffer, redirect handling and fault halt.
module instr_fetch #(
  parameter int              PC_W       = rv32_pkg::PC_W,
  parameter int              IMEM_BYTES = 4096,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [7:0]      prog_data,
  input  logic            start,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  output logic            fault
);
  import rv32_pkg::*;

  localparam int ROWS    = IMEM_BYTES / WORD_BYTES;
  localparam int ROW_W   = $clog2(ROWS);
  localparam int ENTRY_W = 32 + PC_W;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic            fault_q, fault_d;

  logic               run, redirect_take, redirect_bad, transfer, issue;
  logic [2:0]         level;
  logic               fifo_push, fifo_pop, fifo_flush;
  logic [ENTRY_W-1:0] fifo_head;
  logic [1:0]         fifo_count;
  logic [31:0]        rdata;
  logic [ROW_W-1:0]   wr_row, rd_row;
  logic               mem_we;

  assign wr_row = ROW_W'(prog_addr >> 2);
  assign rd_row = ROW_W'(pc_q >> 2);
  assign mem_we = prog_we && (state_q == ST_LOAD);

  // One byte lane per bank so a whole aligned word comes out of one read.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_bank
      logic [7:0] bank_mem [ROWS];
      logic [7:0] rd_q;
      // Byte write while loading; registered word-lane read on each issue.
      always_ff @(posedge clk) begin
        if (mem_we && (prog_addr[1:0] == 2'(gi))) bank_mem[wr_row] <= prog_data;
        if (issue) rd_q <= bank_mem[rd_row];
      end
      assign rdata[8*gi +: 8] = rd_q;
    end
  endgenerate

  // Issue/flush decisions. The buffer budget counts the slot freed by this
  // cycle's transfer so a ready datapath sees one instruction per cycle.
  always_comb begin
    run           = (state_q == ST_RUN);
    redirect_take = run && redirect_valid;
    redirect_bad  = redirect_take && !is_aligned(redirect_pc[1:0]);
    transfer      = inst_valid && inst_ready;
    level         = 3'(fifo_count) + 3'(inflight_q) - 3'(transfer);
    issue         = run && !redirect_valid && (level < 3'd2);
    fifo_flush    = redirect_take;
    fifo_pop      = run && !redirect_valid && transfer && (fifo_count != 2'd0);
    // Arriving read data bypasses the FIFO when it is empty and taken at once.
    fifo_push     = run && !redirect_valid && inflight_q &&
                    !((fifo_count == 2'd0) && transfer);
  end

  // Next PC, in-flight tracking and sticky fault.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? pc_q : inflight_pc_q;
    fault_d       = fault_q | redirect_bad;
    if ((state_q == ST_LOAD) && start) pc_d = RESET_PC;
    else if (redirect_take)            pc_d = redirect_pc;
    else if (issue)                    pc_d = pc_q + PC_W'(WORD_BYTES);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fault_q       <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fault_q       <= fault_d;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_LOAD;
    else       state_q <= state_d;
  end

  // Next-state logic: HALT is left only through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: if (start)        state_d = ST_RUN;
      ST_RUN:  if (redirect_bad) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_LOAD;
    endcase
  end

  // Outputs: FIFO head first, otherwise the word arriving from memory.
  always_comb begin
    inst_valid = 1'b0;
    inst       = '0;
    inst_pc    = '0;
    if (!reset && run) begin
      if (fifo_count != 2'd0) begin
        inst_valid = 1'b1;
        inst       = fifo_head[ENTRY_W-1 -: 32];
        inst_pc    = fifo_head[PC_W-1:0];
      end else if (inflight_q) begin
        inst_valid = 1'b1;
        inst       = rdata;
        inst_pc    = inflight_pc_q;
      end
    end
  end

  assign fault = fault_q;

  fetch_fifo #(.DW(ENTRY_W)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i ({rdata, inflight_pc_q}),
    .pop_i       (fifo_pop),
    .flush_i     (fifo_flush),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: cycle table, hand sequences, randomized stream check.
module tb_instr_fetch;

  logic        clk;
  logic        reset, prog_we, start, redirect_valid, inst_ready;
  logic [11:0] prog_addr, redirect_pc;
  logic [7:0]  prog_data;
  logic        inst_valid, fault, v2, fault2;
  logic [31:0] inst, inst2;
  logic [11:0] inst_pc, pc2;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.PC_W(12), .IMEM_BYTES(4096), .RESET_PC(12'h000)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .fault(fault)
  );

  instr_fetch #(.PC_W(12), .IMEM_BYTES(4096), .RESET_PC(12'hFF8)) dut_hi (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(v2), .inst_ready(inst_ready),
    .inst(inst2), .inst_pc(pc2), .fault(fault2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, st, rdy, rv;
    logic [11:0] rpc;
    logic        ev;
    logic [31:0] einst;
    logic [11:0] epc;
    logic        ef;
    logic        cz;
  } vec_t;

  vec_t        tbl [28];
  logic [31:0] prog_w [8];
  logic [7:0]  mem_model [4096];

  function automatic vec_t mk(input logic rst, input logic st, input logic rdy,
                              input logic rv, input logic [11:0] rpc, input logic ev,
                              input logic [31:0] einst, input logic [11:0] epc,
                              input logic ef, input logic cz);
    vec_t v;
    v.rst = rst; v.st = st; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.einst = einst; v.epc = epc; v.ef = ef; v.cz = cz;
    return v;
  endfunction

  function automatic logic [31:0] mword(input logic [11:0] a);
    logic [11:0] a1, a2, a3;
    a1 = a + 12'd1; a2 = a + 12'd2; a3 = a + 12'd3;
    return {mem_model[a3], mem_model[a2], mem_model[a1], mem_model[a]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [11:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  initial begin
    logic [11:0] exp_pc, prev_pc;
    logic [31:0] prev_inst, wv;
    logic        red_d1, red_d2, stall_d, xfer_d, rv;
    logic [11:0] rpc;

    prog_w[0] = 32'h00500613; prog_w[1] = 32'h00B06693;
    prog_w[2] = 32'h00C00713; prog_w[3] = 32'h00D00793;
    prog_w[4] = 32'h01000813; prog_w[5] = 32'h01100893;
    prog_w[6] = 32'h01200913; prog_w[7] = 32'h01300993;

    tbl[0]  = mk(0,1,1,0,12'h000, 0,32'h0,12'h000,0,0);
    tbl[1]  = mk(0,0,1,0,12'h000, 0,32'h0,12'h000,0,0);
    tbl[2]  = mk(0,0,1,0,12'h000, 1,prog_w[0],12'h000,0,0);
    tbl[3]  = mk(0,0,1,0,12'h000, 1,prog_w[1],12'h004,0,0);
    tbl[4]  = mk(0,0,1,0,12'h000, 1,prog_w[2],12'h008,0,0);
    tbl[5]  = mk(1,0,1,0,12'h000, 0,32'h0,12'h000,0,0);
    tbl[6]  = mk(0,1,0,0,12'h000, 0,32'h0,12'h000,0,1);
    tbl[7]  = mk(0,0,0,0,12'h000, 0,32'h0,12'h000,0,0);
    for (int r = 8; r <= 12; r++) tbl[r] = mk(0,0,0,0,12'h000, 1,prog_w[0],12'h000,0,0);
    tbl[13] = mk(0,0,1,0,12'h000, 1,prog_w[0],12'h000,0,0);
    tbl[14] = mk(0,0,1,1,12'h010, 1,prog_w[1],12'h004,0,0);
    tbl[15] = mk(0,0,1,0,12'h000, 0,32'h0,12'h000,0,0);
    tbl[16] = mk(0,0,1,0,12'h000, 1,prog_w[4],12'h010,0,0);
    tbl[17] = mk(0,0,1,0,12'h000, 1,prog_w[5],12'h014,0,0);
    tbl[18] = mk(0,0,1,1,12'h012, 1,prog_w[6],12'h018,0,0);
    tbl[19] = mk(0,0,1,0,12'h000, 0,32'h0,12'h000,1,0);
    tbl[20] = mk(0,1,1,0,12'h000, 0,32'h0,12'h000,1,0);
    tbl[21] = mk(0,0,1,1,12'h020, 0,32'h0,12'h000,1,0);
    tbl[22] = mk(1,0,1,0,12'h000, 0,32'h0,12'h000,1,0);
    tbl[23] = mk(0,0,1,1,12'h012, 0,32'h0,12'h000,0,1);
    tbl[24] = mk(0,1,1,0,12'h000, 0,32'h0,12'h000,0,0);
    tbl[25] = mk(0,0,1,0,12'h000, 0,32'h0,12'h000,0,0);
    tbl[26] = mk(0,0,1,0,12'h000, 1,prog_w[0],12'h000,0,0);
    tbl[27] = mk(0,0,1,0,12'h000, 1,prog_w[1],12'h004,0,0);

    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    chk("reset_valid", 64'(inst_valid), 64'(0));
    chk("reset_inst",  64'(inst),       64'(0));
    chk("reset_pc",    64'(inst_pc),    64'(0));
    chk("reset_fault", 64'(fault),      64'(0));
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      for (int b = 0; b < 4; b++)
        load_byte(12'(i * 4 + b), prog_w[i][8*b +: 8]);

    // Cycle-exact table.
    for (int r = 0; r < 28; r++) begin
      reset = tbl[r].rst; start = tbl[r].st; inst_ready = tbl[r].rdy;
      redirect_valid = tbl[r].rv; redirect_pc = tbl[r].rpc;
      #3;
      $display("row %0d: valid=%0b inst=%h pc=%h fault=%0b", r, inst_valid, inst, inst_pc, fault);
      chk($sformatf("row%0d_valid", r), 64'(inst_valid), 64'(tbl[r].ev));
      if (tbl[r].ev || tbl[r].cz) begin
        chk($sformatf("row%0d_inst", r), 64'(inst),    64'(tbl[r].einst));
        chk($sformatf("row%0d_pc", r),   64'(inst_pc), 64'(tbl[r].epc));
      end
      chk($sformatf("row%0d_fault", r), 64'(fault), 64'(tbl[r].ef));
      tick();
    end
    reset = 1'b0; start = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset with two buffered entries.
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    #3;
    $display("hold: valid=%0b inst=%h pc=%h", inst_valid, inst, inst_pc);
    chk("hold_valid", 64'(inst_valid), 64'(1));
    chk("hold_inst",  64'(inst),       64'(prog_w[0]));
    tick();
    reset = 1'b1; inst_ready = 1'b1;
    #3;
    chk("rst_cycle_valid", 64'(inst_valid), 64'(0));
    tick();
    reset = 1'b0;
    #3;
    $display("after reset: valid=%0b inst=%h pc=%h", inst_valid, inst, inst_pc);
    chk("post_rst_valid", 64'(inst_valid), 64'(0));
    chk("post_rst_inst",  64'(inst),       64'(0));
    chk("post_rst_pc",    64'(inst_pc),    64'(0));
    tick(); tick();
    #3;
    chk("load_idle_valid", 64'(inst_valid), 64'(0));
    tick();

    // Byte writes while running must not reach memory.
    start = 1'b1; tick(); start = 1'b0; inst_ready = 1'b0;
    tick();
    load_byte(12'h000, 8'hFF);
    load_byte(12'h005, 8'hEE);
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; inst_ready = 1'b1; tick(); start = 1'b0;
    tick();
    #3;
    $display("run write: valid=%0b inst=%h pc=%h", inst_valid, inst, inst_pc);
    chk("runwr_valid", 64'(inst_valid), 64'(1));
    chk("runwr_inst0", 64'(inst),       64'(prog_w[0]));
    tick();
    #3;
    chk("runwr_inst1", 64'(inst), 64'(prog_w[1]));
    tick();

    // PC wrap from the top of the address space (second instance).
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 4; i++) load_byte(12'hFF8 + 12'(i), 8'(32'hDEADBEEF >> (8 * i)));
    for (int i = 0; i < 4; i++) load_byte(12'hFFC + 12'(i), 8'(32'hCAFEF00D >> (8 * i)));
    start = 1'b1; inst_ready = 1'b1; tick(); start = 1'b0;
    #3;
    chk("wrap_lat_valid", 64'(v2), 64'(0));
    tick(); #3;
    $display("wrap: valid=%0b inst=%h pc=%h", v2, inst2, pc2);
    chk("wrap0_valid", 64'(v2), 64'(1));
    chk("wrap0_pc", 64'(pc2), 64'(12'hFF8));
    chk("wrap0_inst", 64'(inst2), 64'(32'hDEADBEEF));
    tick(); #3;
    $display("wrap: valid=%0b inst=%h pc=%h", v2, inst2, pc2);
    chk("wrap1_pc", 64'(pc2), 64'(12'hFFC));
    chk("wrap1_inst", 64'(inst2), 64'(32'hCAFEF00D));
    tick(); #3;
    $display("wrap: valid=%0b inst=%h pc=%h", v2, inst2, pc2);
    chk("wrap2_valid", 64'(v2), 64'(1));
    chk("wrap2_pc", 64'(pc2), 64'(12'h000));
    chk("wrap2_inst", 64'(inst2), 64'(prog_w[0]));
    tick();

    // Randomized run against an in-order instruction-stream model.
    inst_ready = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      mem_model[i] = 8'($urandom);
      load_byte(12'(i), mem_model[i]);
    end
    start = 1'b1; tick(); start = 1'b0;
    exp_pc = 12'h000; red_d1 = 1'b0; red_d2 = 1'b0; stall_d = 1'b0; xfer_d = 1'b0;
    prev_inst = '0; prev_pc = '0;
    for (int c = 0; c < 1500; c++) begin
      inst_ready = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = 12'($urandom_range(0, 1023) * 4);
      redirect_valid = rv; redirect_pc = rpc;
      #3;
      if (red_d1)      chk("rnd_flush_valid", 64'(inst_valid), 64'(0));
      else if (red_d2) chk("rnd_target_valid", 64'(inst_valid), 64'(1));
      if (stall_d && !red_d1) begin
        chk("rnd_stall_valid", 64'(inst_valid), 64'(1));
        chk("rnd_stall_inst",  64'(inst),       64'(prev_inst));
        chk("rnd_stall_pc",    64'(inst_pc),    64'(prev_pc));
      end
      if (xfer_d && !red_d1) chk("rnd_stream_valid", 64'(inst_valid), 64'(1));
      if (inst_valid && inst_ready) begin
        wv = mword(exp_pc);
        $display("xfer pc=%h inst=%h exp_pc=%h exp_inst=%h", inst_pc, inst, exp_pc, wv);
        chk("rnd_xfer_pc",   64'(inst_pc), 64'(exp_pc));
        chk("rnd_xfer_inst", 64'(inst),    64'(wv));
        exp_pc = exp_pc + 12'd4;
      end
      stall_d = inst_valid && !inst_ready;
      xfer_d  = inst_valid && inst_ready;
      prev_inst = inst; prev_pc = inst_pc;
      red_d2 = red_d1; red_d1 = rv;
      if (rv) exp_pc = rpc;
      tick();
    end
    redirect_valid = 1'b0;
    #3;
    chk("rnd_fault", 64'(fault), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
